// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for the instruction sequencer and control_unit:
// opcode constants, FSM state encodings and a legality helper.
package instr_sequencer_pkg;

  localparam logic [4:0] OP_I  = 5'b00001;
  localparam logic [4:0] OP_AR = 5'b00010;
  localparam logic [4:0] OP_J  = 5'b00011;
  localparam logic [4:0] OP_M  = 5'b00100;
  localparam logic [4:0] OP_T  = 5'b01011;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_WB     = 3'd3,
    ST_HALT   = 3'd4,
    ST_FAULT  = 3'd5
  } state_t;

  function automatic logic isLegal(input logic [4:0] op);
    logic ok;
    ok = 1'b0;
    unique case (1'b1)
      (op == OP_I),
      (op == OP_AR),
      (op == OP_J),
      (op == OP_M),
      (op == OP_T): ok = 1'b1;
      default:      ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/instr_sequencer_timer.sv
// Down-counter with load, decrement and zero flag; used for the fetch
// timeout and the EXEC latency count.
module seq_timer #(
  parameter int W      = 4,
  parameter int RSTVAL = 0
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         load,
  input  logic [W-1:0] loadVal,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt <= W'(RSTVAL);
    end else if (load) begin
      cnt <= loadVal;
    end else if (dec && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/WB sequencer producing single-cycle
// IR-load, register-write and PC-update strobes.
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter int ALU_LAT = 1,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             halt_req,
  output logic             imem_req,
  input  logic             imem_ack,
  input  logic [4:0]       opcode,
  input  logic             dec_regWrite,
  input  logic             branchIdea,
  output logic             ir_load,
  output logic             reg_we,
  output logic             pc_write,
  output logic             pc_sel,
  output logic             illegal_op,
  output logic             fault,
  output logic             halted,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instr_count
);

  localparam int FW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int EW = (ALU_LAT > 1) ? $clog2(ALU_LAT + 1) : 1;

  state_t curState, nextState, doneState;
  logic running;
  logic fetchLoad, fetchDec, fetchZero;
  logic execLoad, execDec, execZero;
  logic irLoad, regWe, pcWrite, pcSel, illegalOp;
  logic [CNT_W-1:0] instrCount;

  // First cycle out of reset is not a fetch: it samples halt_req as
  // the FETCH entry and keeps every output low while reset settles.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      curState <= ST_FETCH;
      running  <= 1'b0;
    end else begin
      curState <= nextState;
      running  <= 1'b1;
    end
  end

  seq_timer #(.W(FW), .RSTVAL(TIMEOUT - 1)) uFetchTimer (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .load    (fetchLoad),
    .loadVal (FW'(TIMEOUT - 1)),
    .dec     (fetchDec),
    .zero    (fetchZero)
  );

  seq_timer #(.W(EW), .RSTVAL(0)) uExecTimer (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .load    (execLoad),
    .loadVal (EW'(ALU_LAT - 1)),
    .dec     (execDec),
    .zero    (execZero)
  );

  always_comb begin
    nextState = curState;
    irLoad    = 1'b0;
    regWe     = 1'b0;
    pcWrite   = 1'b0;
    pcSel     = 1'b0;
    illegalOp = 1'b0;
    fetchDec  = 1'b0;
    execLoad  = 1'b0;
    execDec   = 1'b0;
    doneState = halt_req ? ST_HALT : ST_FETCH;
    unique case (curState)
      ST_FETCH: begin
        if (!running) begin
          nextState = doneState;
        end else if (imem_ack) begin
          irLoad    = 1'b1;
          nextState = ST_DECODE;
        end else if (fetchZero) begin
          nextState = ST_FAULT;
        end else begin
          fetchDec = 1'b1;
        end
      end
      ST_DECODE: begin
        if (isLegal(opcode)) begin
          execLoad  = 1'b1;
          nextState = ST_EXEC;
        end else begin
          illegalOp = 1'b1;
          pcWrite   = 1'b1;
          nextState = doneState;
        end
      end
      ST_EXEC: begin
        if (!execZero) begin
          execDec = 1'b1;
        end else if (opcode == OP_J) begin
          pcWrite   = 1'b1;
          pcSel     = 1'b1;
          nextState = doneState;
        end else if (opcode == OP_M) begin
          pcWrite   = 1'b1;
          pcSel     = branchIdea;
          nextState = doneState;
        end else begin
          nextState = ST_WB;
        end
      end
      ST_WB: begin
        regWe     = dec_regWrite;
        pcWrite   = 1'b1;
        nextState = doneState;
      end
      ST_HALT: begin
        if (!halt_req) nextState = ST_FETCH;
      end
      default: nextState = curState;
    endcase
    fetchLoad = (nextState == ST_FETCH) &&
                (curState != ST_FETCH || !running);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      instrCount <= '0;
    end else if (pcWrite && instrCount != '1) begin
      instrCount <= instrCount + 1'b1;
    end
  end

  assign imem_req    = (curState == ST_FETCH) && running;
  assign ir_load     = irLoad;
  assign reg_we      = regWe;
  assign pc_write    = pcWrite;
  assign pc_sel      = pcSel;
  assign illegal_op  = illegalOp;
  assign fault       = (curState == ST_FAULT);
  assign halted      = (curState == ST_HALT);
  assign state       = curState;
  assign instr_count = instrCount;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed and randomized bench for instr_sequencer against a
// per-instruction latency/strobe model.
module tb_instr_sequencer;

  localparam int LAT   = 1;
  localparam int TOUT  = 16;
  localparam int CW    = 16;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  logic haltReq = 1'b0;
  logic imemAck = 1'b0;
  logic [4:0] opcode = 5'd0;
  logic regWrite = 1'b0;
  logic branchIdea = 1'b0;

  logic imemReq, irLoad, regWe, pcWrite, pcSel, illegalOp, fault, halted;
  logic [2:0] state;
  logic [CW-1:0] instrCount;

  logic imemReq3, irLoad3, regWe3, pcWrite3, pcSel3, illegalOp3;
  logic fault3, halted3;
  logic [2:0] state3;
  logic [CW-1:0] instrCount3;

  int checks = 0;
  int failures = 0;
  int modelCount = 0;

  always #5 CLK = ~CLK;

  instr_sequencer #(.ALU_LAT(LAT), .TIMEOUT(TOUT), .CNT_W(CW)) dut (
    .CLK(CLK), .RST_N(RST_N), .halt_req(haltReq),
    .imem_req(imemReq), .imem_ack(imemAck), .opcode(opcode),
    .dec_regWrite(regWrite), .branchIdea(branchIdea),
    .ir_load(irLoad), .reg_we(regWe), .pc_write(pcWrite),
    .pc_sel(pcSel), .illegal_op(illegalOp), .fault(fault),
    .halted(halted), .state(state), .instr_count(instrCount)
  );

  instr_sequencer #(.ALU_LAT(3), .TIMEOUT(TOUT), .CNT_W(CW)) dut3 (
    .CLK(CLK), .RST_N(RST_N), .halt_req(haltReq),
    .imem_req(imemReq3), .imem_ack(imemAck), .opcode(opcode),
    .dec_regWrite(regWrite), .branchIdea(branchIdea),
    .ir_load(irLoad3), .reg_we(regWe3), .pc_write(pcWrite3),
    .pc_sel(pcSel3), .illegal_op(illegalOp3), .fault(fault3),
    .halted(halted3), .state(state3), .instr_count(instrCount3)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit legalRef(input logic [4:0] op);
    logic [4:0] tbl [5];
    tbl = '{5'b00010, 5'b01011, 5'b00001, 5'b00011, 5'b00100};
    foreach (tbl[k]) if (tbl[k] == op) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void bumpCount();
    modelCount = (modelCount == 65535) ? 65535 : modelCount + 1;
  endfunction

  task automatic doReset();
    RST_N = 1'b0;
    haltReq = 1'b0;
    imemAck = 1'b0;
    modelCount = 0;
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
  endtask

  // Caller is at the negedge of the first FETCH cycle.
  task automatic runInstr(input logic [4:0] op, input bit rw,
                          input bit br, input int dly);
    int n;
    int expLat;
    bit early;
    bit isJ, isM, legal;
    legal = legalRef(op);
    isJ = (op == 5'b00011);
    isM = (op == 5'b00100);
    expLat = !legal ? 1 : (isJ || isM) ? 1 + LAT : 2 + LAT;
    opcode = op;
    regWrite = rw;
    branchIdea = br;
    check("fetch_req", 32'(imemReq), 1);
    repeat (dly) @(negedge CLK);
    imemAck = 1'b1;
    #1;
    check("ir_load", 32'(irLoad), 1);
    @(negedge CLK);
    imemAck = 1'b0;
    check("req_drop", 32'(imemReq), 0);
    n = 1;
    early = 1'b0;
    while (!pcWrite && n < 12) begin
      if (regWe) early = 1'b1;
      @(negedge CLK);
      n++;
    end
    check("latency", 32'(n), 32'(expLat));
    check("early_we", 32'(early), 0);
    check("pc_sel", 32'(pcSel), 32'(isJ || (isM && br)));
    check("reg_we", 32'(regWe), 32'(legal && !isJ && !isM && rw));
    check("illegal_op", 32'(illegalOp), 32'(!legal));
    bumpCount();
    @(negedge CLK);
    check("instr_count", 32'(instrCount), 32'(modelCount));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] op;
    int n;

    // Reset state
    RST_N = 1'b0;
    @(negedge CLK);
    check("rst_state", 32'(state), 0);
    check("rst_req", 32'(imemReq), 0);
    check("rst_strobes",
          32'({irLoad, regWe, pcWrite, pcSel, illegalOp}), 0);
    check("rst_flags", 32'({fault, halted}), 0);
    check("rst_count", 32'(instrCount), 0);
    RST_N = 1'b1;
    @(negedge CLK);

    // AR, M taken, M not taken, illegal, late ack
    runInstr(5'b00010, 1'b1, 1'b0, 0);
    runInstr(5'b00100, 1'b1, 1'b1, 0);
    runInstr(5'b00100, 1'b1, 1'b0, 2);
    runInstr(5'b11111, 1'b1, 1'b1, 0);
    runInstr(5'b01011, 1'b1, 1'b0, TOUT - 1);
    check("late_ack_fault", 32'(fault), 0);

    // J with halt raised in EXEC
    opcode = 5'b00011;
    imemAck = 1'b1;
    @(negedge CLK);
    imemAck = 1'b0;
    @(negedge CLK);
    haltReq = 1'b1;
    #1;
    check("j_pc_write", 32'(pcWrite), 1);
    check("j_pc_sel", 32'(pcSel), 1);
    bumpCount();
    @(negedge CLK);
    check("halt_state", 32'(state), 4);
    check("halt_flag", 32'(halted), 1);
    @(negedge CLK);
    check("halt_no_req", 32'(imemReq), 0);
    check("halt_count", 32'(instrCount), 32'(modelCount));
    haltReq = 1'b0;
    @(negedge CLK);
    check("unhalt_req", 32'(imemReq), 1);
    check("unhalt_flag", 32'(halted), 0);

    // Randomized instruction stream
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 5))
        0: op = 5'b00010;
        1: op = 5'b01011;
        2: op = 5'b00001;
        3: op = 5'b00011;
        4: op = 5'b00100;
        default: begin
          op = 5'($urandom);
          for (int k = 0; k < 64 && legalRef(op); k++) op = 5'($urandom);
        end
      endcase
      runInstr(op, 1'($urandom), 1'($urandom),
               int'($urandom_range(0, TOUT - 1)));
    end
    check("rand_fault", 32'(fault), 0);

    // Fetch timeout
    repeat (TOUT) @(negedge CLK);
    check("to_state", 32'(state), 5);
    check("to_fault", 32'(fault), 1);
    check("to_req", 32'(imemReq), 0);
    imemAck = 1'b1;
    repeat (3) @(negedge CLK);
    imemAck = 1'b0;
    check("to_sticky", 32'({state, fault, irLoad}), 32'({3'd5, 1'b1, 1'b0}));

    // Reset during WB
    doReset();
    opcode = 5'b00010;
    regWrite = 1'b1;
    imemAck = 1'b1;
    @(negedge CLK);
    imemAck = 1'b0;
    repeat (2) @(negedge CLK);
    check("pre_wb_state", 32'(state), 3);
    RST_N = 1'b0;
    #1;
    check("wbrst_we", 32'({regWe, pcWrite}), 0);
    check("wbrst_state", 32'(state), 0);
    check("wbrst_flags", 32'({imemReq, fault, halted}), 0);
    check("wbrst_count", 32'(instrCount), 0);
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);

    // ALU_LAT=3 instance: I spends three cycles in EXEC
    doReset();
    opcode = 5'b00001;
    regWrite = 1'b1;
    imemAck = 1'b1;
    #1;
    check("lat3_ir_load", 32'(irLoad3), 1);
    @(negedge CLK);
    imemAck = 1'b0;
    @(negedge CLK);
    n = 0;
    while (state3 == 3'd2 && n < 10) begin
      check("lat3_no_pc", 32'(pcWrite3), 0);
      @(negedge CLK);
      n++;
    end
    check("lat3_exec_cycles", 32'(n), 3);
    check("lat3_wb", 32'({state3, regWe3, pcWrite3, pcSel3}),
          32'({3'd3, 1'b1, 1'b1, 1'b0}));
    @(negedge CLK);
    check("lat3_count", 32'(instrCount3), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
